// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode/func constants, ALU control codes and datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_e;

  // Which ALU decode rule applies in the current state.
  typedef enum logic [2:0] {
    AC_NONE,
    AC_ADD,
    AC_SUB,
    AC_FUNC,
    AC_IMM
  } alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // R-type funcs the core actually implements; anything else is illegal.
  function automatic logic func_legal(input logic [5:0] func);
    case (func)
      FN_NOP, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: func_legal = 1'b1;
      default:                                       func_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps the state's ALU class plus op/func to the
// 3-bit ALU operation code.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_class_e  cls,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  output logic [2:0]  alu_ctrl
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives the output
    // and no latch is inferred.
    alu_ctrl = ALU_AND;
    case (cls)
      AC_NONE: alu_ctrl = ALU_AND;
      AC_ADD:  alu_ctrl = ALU_ADD;
      AC_SUB:  alu_ctrl = ALU_SUB;
      AC_FUNC: begin
        case (func)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      AC_IMM: begin
        case (op)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with mem_ready handshake and retired counter.
// Optional illegal-instruction trap: define MC_CTRL_ILLEGAL_TRAP_EN.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_e S_ILLEGAL = S_HALT;
`else
  // Illegal instructions fall back to FETCH; PC already advanced, so they act as NOPs.
  localparam state_e S_ILLEGAL = S_FETCH;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  alu_class_e       alu_cls;

  logic pc_en_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  // Next-state and retire decision.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_RTYPE:                           state_d = func_legal(func) ? S_REX : S_ILLEGAL;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_IEX;
          OP_J:                               state_d = S_JUMP;
          default:                            state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
      S_REX:    state_d = S_RWB;
      S_RWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
      S_IEX:    state_d = S_IWB;
      S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_ONE;
    end
  end

  // Moore output decode; only pc_en/ir_write look at mem_ready or zero.
  always_comb begin
    pc_en_raw     = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU;
    alu_cls       = AC_NONE;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        alu_cls      = AC_ADD;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_cls   = AC_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = AC_ADD;
      end
      S_MEMRD:  i_or_d = 1'b1;
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_cls   = AC_FUNC;
      end
      S_RWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cls   = AC_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en_raw = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = AC_IMM;
      end
      S_IWB:    reg_write_raw = 1'b1;
      S_JUMP: begin
        pc_src    = PCSRC_JUMP;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls      (alu_cls),
    .op       (op),
    .func     (func),
    .alu_ctrl (alu_ctrl)
  );

  // Writes are suppressed combinationally while reset is held, so nothing
  // partial escapes during the reset cycle.
  assign pc_en     = pc_en_raw     & rst;
  assign ir_write  = ir_write_raw  & rst;
  assign mem_write = mem_write_raw & rst;
  assign reg_write = reg_write_raw & rst;

  assign state   = state_q;
  assign retired = retired_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
